// File: rtl/wb_pad_ctrl.sv
// Wishbone-controlled pad ownership mux with synchronised inputs, per-pad edge capture
// and edge interrupts folded onto user_irq.
module wb_pad_ctrl #(
  parameter int          IO_PADS     = 38,
  parameter int          IRQ_LINES   = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic [IO_PADS-1:0]   core_io_out,
  input  logic [IO_PADS-1:0]   core_io_oeb,
  input  logic [IO_PADS-1:0]   io_in,
  output logic [IO_PADS-1:0]   io_out,
  output logic [IO_PADS-1:0]   io_oeb,
  output logic [IRQ_LINES-1:0] user_irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic        ack_reg;
  logic [31:0] dat_reg;

  logic [IO_PADS-1:0] out_reg, oeb_reg, own_reg, rise_en_reg, fall_en_reg, stat_reg;
  logic [IO_PADS-1:0] s1_reg, s2_reg, prev_reg;

  logic               req, hit, commit, wr_en;
  logic [2:0]         reg_k;
  logic [IO_PADS-1:0] wr_mask, wr_bits;
  logic [IO_PADS-1:0] edge_set, stat_clr, stat_next;
  logic [IO_PADS-1:0] rd_pads;
  logic [63:0]        rd_wide;
  logic [31:0]        rd_word;
  logic               unused_ok;

  assign req    = wbs_cyc_i & wbs_stb_i;
  assign hit    = (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
  assign reg_k  = wbs_adr_i[5:3];
  assign commit = (state_reg == ST_ACK) && req;
  assign wr_en  = commit && wbs_we_i && hit;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0]};

  // Each pad bit lives in the LO word (pads 0..31) or HI word (32..63) under one byte lane.
  genvar gi;
  generate
    for (gi = 0; gi < IO_PADS; gi++) begin : g_pad
      assign wr_mask[gi] = (wbs_adr_i[2] == (gi >= 32)) && wbs_sel_i[(gi % 32) / 8];
      assign wr_bits[gi] = wbs_dat_i[gi % 32];
      assign io_out[gi]  = own_reg[gi] ? out_reg[gi] : core_io_out[gi];
      assign io_oeb[gi]  = own_reg[gi] ? oeb_reg[gi] : core_io_oeb[gi];
    end

    for (gi = 0; gi < IRQ_LINES; gi++) begin : g_irq
      logic line_or;
      always_comb begin
        line_or = 1'b0;
        for (int p = gi; p < IO_PADS; p += IRQ_LINES) line_or = line_or | stat_reg[p];
      end
      assign user_irq[gi] = line_or;
    end
  endgenerate

  function automatic logic [IO_PADS-1:0] merge(input logic [IO_PADS-1:0] old_val);
    return (old_val & ~wr_mask) | (wr_bits & wr_mask);
  endfunction

  // A capture event in the same cycle as a W1C clear takes precedence.
  assign edge_set  = (s2_reg & ~prev_reg & rise_en_reg) | (~s2_reg & prev_reg & fall_en_reg);
  assign stat_clr  = (wr_en && reg_k == 3'd6) ? (wr_mask & wr_bits) : '0;
  assign stat_next = (stat_reg & ~stat_clr) | edge_set;

  always_comb begin
    rd_pads = '0;
    case (reg_k)
      3'd0:    rd_pads = out_reg;
      3'd1:    rd_pads = oeb_reg;
      3'd2:    rd_pads = s2_reg;
      3'd3:    rd_pads = own_reg;
      3'd4:    rd_pads = rise_en_reg;
      3'd5:    rd_pads = fall_en_reg;
      3'd6:    rd_pads = stat_reg;
      default: rd_pads = '0;
    endcase
    rd_wide = '0;
    rd_wide[IO_PADS-1:0] = rd_pads;
    rd_word = '0;
    if (hit) rd_word = wbs_adr_i[2] ? rd_wide[63:32] : rd_wide[31:0];
  end

  // Bus FSM; ack_reg still high in IDLE blocks an immediate re-accept of a held strobe.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      ack_reg      <= 1'b0;
      dat_reg      <= '0;
    end else begin
      ack_reg <= 1'b0;
      dat_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (req && !ack_reg) begin
            if (WAIT_STATES == 0) begin
              state_reg <= ST_ACK;
            end else begin
              state_reg    <= ST_WAIT;
              wait_cnt_reg <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!req)                   state_reg    <= ST_IDLE;
          else if (wait_cnt_reg <= 1) state_reg    <= ST_ACK;
          else                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end
        ST_ACK: begin
          state_reg <= ST_IDLE;
          if (req) begin
            ack_reg <= 1'b1;
            if (!wbs_we_i) dat_reg <= rd_word;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_reg     <= '0;
      oeb_reg     <= '1;
      own_reg     <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      stat_reg    <= '0;
    end else begin
      if (wr_en && reg_k == 3'd0) out_reg     <= merge(out_reg);
      if (wr_en && reg_k == 3'd1) oeb_reg     <= merge(oeb_reg);
      if (wr_en && reg_k == 3'd3) own_reg     <= merge(own_reg);
      if (wr_en && reg_k == 3'd4) rise_en_reg <= merge(rise_en_reg);
      if (wr_en && reg_k == 3'd5) fall_en_reg <= merge(fall_en_reg);
      stat_reg <= stat_next;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      prev_reg <= '0;
    end else begin
      s1_reg   <= io_in;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;

endmodule
